// File: rtl/rr_arb_mux.sv
// N-channel registered mux with valid/ready handshake and round-robin arbitration.
// Define RR_ARB_MUX_PRIO_EN for fixed lowest-index-first priority instead.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*WIDTH-1:0]  in_data,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  input  logic                  out_ready
);

  logic [NCH-1:0][WIDTH-1:0] ch_data;
  logic [SELW-1:0]           ptr;
  logic [SELW-1:0]           gnt_idx;
  logic [SELW:0]             sum;
  logic [2*NCH-1:0]          dbl;
  logic [NCH-1:0]            rot;
  logic [NCH-1:0]            gnt;
  logic                      found;
  logic                      can_load;
  logic                      load;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Rotate requests so bit 0 is the channel at ptr; first set bit wins.
  assign dbl = {in_valid, in_valid} >> ptr;
  assign rot = dbl[NCH-1:0];

  always_comb begin
    found   = 1'b0;
    sum     = '0;
    gnt_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (SELW+1)'(k);
      end
    end
    if (sum >= (SELW+1)'(NCH)) sum = sum - (SELW+1)'(NCH);
    gnt_idx = sum[SELW-1:0];
  end

  assign gnt      = found ? (NCH'(1) << gnt_idx) : '0;
  assign can_load = ~out_valid | out_ready;
  assign in_ready = can_load ? gnt : '0;
  assign load     = found & can_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[gnt_idx];
      out_ch    <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_ARB_MUX_PRIO_EN
  assign ptr = '0;
`else
  // Pointer moves one past the winner so it ends up lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (load)
      ptr <= (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

endmodule
